// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Byte enables driven for fetches (no write).
    localparam logic [3:0] WEN_NONE = 4'b0000;

    typedef enum logic [2:0] {
        StIdle,
        StIAddr,
        StIData,
        StDAddr,
        StDData,
        StResp
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the arbiter.
// slave: arbiter view. master: requester/memory (environment) view.
interface mem_bus_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_ready;
    logic              inst_stall;
    logic              inst_flush;

    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_ready;
    logic              data_stall;

    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    logic [31:0]       inst_wait_cnt;
    logic [31:0]       data_wait_cnt;

    modport slave (
        input  inst_req, inst_addr, inst_flush,
        input  data_req, data_wr, data_wen, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_rdata, inst_ready, inst_stall,
        output data_rdata, data_ready, data_stall,
        output mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
        output inst_wait_cnt, data_wait_cnt
    );

    modport master (
        output inst_req, inst_addr, inst_flush,
        output data_req, data_wr, data_wen, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_rdata, inst_ready, inst_stall,
        input  data_rdata, data_ready, data_stall,
        input  mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
        input  inst_wait_cnt, data_wait_cnt
    );

endinterface

// File: rtl/mem_bus_perf_cnt.sv
// Free-running stall-cycle counters; wrap at 2^32.
module mem_bus_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inst_stall_i,
    input  logic        data_stall_i,
    output logic [31:0] inst_cnt_o,
    output logic [31:0] data_cnt_o
);

    logic [31:0] inst_cnt_q, inst_cnt_d;
    logic [31:0] data_cnt_q, data_cnt_d;

    // Next count: add one per stalled cycle.
    always_comb begin
        inst_cnt_d = inst_cnt_q + {31'b0, inst_stall_i};
        data_cnt_d = data_cnt_q + {31'b0, data_stall_i};
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inst_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            inst_cnt_q <= inst_cnt_d;
            data_cnt_q <= data_cnt_d;
        end
    end

    assign inst_cnt_o = inst_cnt_q;
    assign data_cnt_o = data_cnt_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like port between instruction fetch and data access.
// Data wins unless fetch has waited through DATA_STREAK_MAX data grants.
// Optional stall counters: define MEM_BUS_ARBITER_PERF_CNT_EN.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned DATA_STREAK_MAX = 2
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);

    localparam int unsigned StreakW =
        (DATA_STREAK_MAX > 0) ? $clog2(DATA_STREAK_MAX + 1) : 1;
    localparam logic [StreakW-1:0] StreakMax = StreakW'(DATA_STREAK_MAX);

    arb_state_e        state_q, state_d;
    logic [StreakW-1:0] streak_q, streak_d;
    logic              discard_q, discard_d;
    logic              wr_q, wr_d;
    logic [3:0]        wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              inst_ready_q, inst_ready_d;
    logic              data_ready_q, data_ready_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    logic in_addr, in_data, fetch_own, done;
    logic inst_stall, data_stall;

    // Next-state, request latching and completion handling.
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        discard_d    = discard_q;
        wr_d         = wr_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        in_addr   = (state_q == StIAddr) || (state_q == StDAddr);
        in_data   = (state_q == StIData) || (state_q == StDData);
        fetch_own = (state_q == StIAddr) || (state_q == StIData);
        done      = (in_addr && bus.mem_addr_ok && bus.mem_data_ok) ||
                    (in_data && bus.mem_data_ok);

        unique case (state_q)
            StIdle: begin
                if (bus.data_req && (!bus.inst_req || (streak_q < StreakMax))) begin
                    state_d  = StDAddr;
                    wr_d     = bus.data_wr;
                    wen_d    = bus.data_wen;
                    addr_d   = bus.data_addr;
                    wdata_d  = bus.data_wdata;
                    streak_d = bus.inst_req ? streak_q + StreakW'(1) : '0;
                end else if (bus.inst_req) begin
                    state_d  = StIAddr;
                    wr_d     = 1'b0;
                    wen_d    = WEN_NONE;
                    addr_d   = bus.inst_addr;
                    wdata_d  = '0;
                    streak_d = '0;
                end
            end
            StIAddr, StDAddr: begin
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) begin
                        state_d = StResp;
                    end else begin
                        state_d = (state_q == StIAddr) ? StIData : StDData;
                    end
                end
            end
            StIData, StDData: begin
                if (bus.mem_data_ok) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d   = StIdle;
                discard_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // A flush landing on the completing cycle still drops the fetch.
        if (fetch_own && bus.inst_flush) begin
            discard_d = 1'b1;
        end

        if (done) begin
            if (fetch_own) begin
                if (!discard_d) begin
                    inst_ready_d = 1'b1;
                    inst_rdata_d = bus.mem_rdata;
                end
            end else begin
                data_ready_d = 1'b1;
                if (!wr_q) begin
                    data_rdata_d = bus.mem_rdata;
                end
            end
        end

        mem_req_d = (state_d == StIAddr) || (state_d == StDAddr);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            streak_q     <= '0;
            discard_q    <= 1'b0;
            wr_q         <= 1'b0;
            wen_q        <= WEN_NONE;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_req_q    <= 1'b0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            discard_q    <= discard_d;
            wr_q         <= wr_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_req_q    <= mem_req_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign inst_stall = bus.inst_req & ~inst_ready_q;
    assign data_stall = bus.data_req & ~data_ready_q;

    assign bus.inst_stall = inst_stall;
    assign bus.data_stall = data_stall;
    assign bus.inst_ready = inst_ready_q;
    assign bus.data_ready = data_ready_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wr     = wr_q;
    assign bus.mem_wen    = wen_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
    logic [31:0] inst_cnt, data_cnt;

    mem_bus_perf_cnt u_perf_cnt (
        .clk_i        (clk),
        .rst_ni       (rst),
        .inst_stall_i (inst_stall),
        .data_stall_i (data_stall),
        .inst_cnt_o   (inst_cnt),
        .data_cnt_o   (data_cnt)
    );

    assign bus.inst_wait_cnt = inst_cnt;
    assign bus.data_wait_cnt = data_cnt;
`else
    assign bus.inst_wait_cnt = '0;
    assign bus.data_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int STREAK = 2;
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .DATA_STREAK_MAX (STREAK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Transaction-level model: one outstanding transfer, described by its owner and progress.
    bit          busy, acc, resp, disc, own_data;
    int          streak;
    logic [31:0] l_addr, l_wdata;
    logic        l_wr;
    logic [3:0]  l_wen;
    logic [31:0] m_irdata, m_drdata, m_icnt, m_dcnt;
    bit          m_iready, m_dready;

    // Memory responder and CPU agent controls.
    int a_lat, d_lat, m_cnt;
    bit comb, rand_mem, auto_cpu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h2408_0001 : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic bit exp_mreq();
        return busy && !acc && !resp;
    endfunction

    task automatic model_reset();
        busy = 0; acc = 0; resp = 0; disc = 0; own_data = 0; streak = 0;
        l_addr = '0; l_wdata = '0; l_wr = 1'b0; l_wen = '0;
        m_irdata = '0; m_drdata = '0; m_icnt = '0; m_dcnt = '0;
        m_iready = 0; m_dready = 0;
    endtask

    task automatic finish_xfer();
        resp = 1; acc = 0;
        if (own_data) begin
            m_dready = 1;
            if (!l_wr) m_drdata = bus.mem_rdata;
        end else begin
            if (!disc) begin
                m_iready = 1;
                m_irdata = bus.mem_rdata;
            end
            disc = 0;
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        if (PerfEn) begin
            m_icnt += {31'b0, bus.inst_req & ~m_iready};
            m_dcnt += {31'b0, bus.data_req & ~m_dready};
        end
        m_iready = 0;
        m_dready = 0;
        if (resp) begin
            resp = 0;
            busy = 0;
        end else if (!busy) begin
            if (bus.data_req && (!bus.inst_req || streak < STREAK)) begin
                busy = 1; acc = 0; own_data = 1;
                l_addr = bus.data_addr; l_wr = bus.data_wr;
                l_wen = bus.data_wen;   l_wdata = bus.data_wdata;
                streak = bus.inst_req ? streak + 1 : 0;
            end else if (bus.inst_req) begin
                busy = 1; acc = 0; own_data = 0;
                l_addr = bus.inst_addr; l_wr = 1'b0; l_wen = 4'b0000; l_wdata = '0;
                streak = 0;
            end
        end else begin
            if (!own_data && bus.inst_flush) disc = 1;
            if (!acc) begin
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) finish_xfer();
                    else acc = 1;
                end
            end else if (bus.mem_data_ok) begin
                finish_xfer();
            end
        end
    endtask

    task automatic compare_all();
        chk1("mem_req", bus.mem_req, exp_mreq());
        if (exp_mreq()) begin
            chk("mem_addr", bus.mem_addr, l_addr);
            chk1("mem_wr", bus.mem_wr, l_wr);
            chk("mem_wen", {28'b0, bus.mem_wen}, {28'b0, l_wen});
            if (l_wr) chk("mem_wdata", bus.mem_wdata, l_wdata);
        end
        chk1("inst_ready", bus.inst_ready, m_iready);
        chk1("data_ready", bus.data_ready, m_dready);
        chk("inst_rdata", bus.inst_rdata, m_irdata);
        chk("data_rdata", bus.data_rdata, m_drdata);
        chk1("inst_stall", bus.inst_stall, bus.inst_req & ~m_iready);
        chk1("data_stall", bus.data_stall, bus.data_req & ~m_dready);
        chk("inst_wait_cnt", bus.inst_wait_cnt, m_icnt);
        chk("data_wait_cnt", bus.data_wait_cnt, m_dcnt);
    endtask

    task automatic mem_agent();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = $urandom;
        if (exp_mreq()) begin
            if (m_cnt >= a_lat) begin
                bus.mem_addr_ok = 1'b1;
                m_cnt = 0;
                if (comb) begin
                    bus.mem_data_ok = 1'b1;
                    bus.mem_rdata   = word(l_addr);
                    if (rand_mem) begin a_lat = $urandom_range(0, 3); comb = ($urandom_range(0, 3) == 0); end
                end else if (rand_mem) begin
                    d_lat = $urandom_range(0, 3);
                end
            end else begin
                m_cnt++;
            end
        end else if (busy && acc && !resp) begin
            if (m_cnt >= d_lat) begin
                bus.mem_data_ok = 1'b1;
                bus.mem_rdata   = word(l_addr);
                m_cnt = 0;
                if (rand_mem) begin a_lat = $urandom_range(0, 3); comb = ($urandom_range(0, 3) == 0); end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cpu_agent();
        if (m_iready) begin
            if ($urandom_range(0, 1) == 1) bus.inst_addr = {$urandom, 2'b00} >> 2 << 2;
            else bus.inst_req = 1'b0;
        end else if (!bus.inst_req && $urandom_range(0, 2) == 0) begin
            bus.inst_req  = 1'b1;
            bus.inst_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (m_dready) begin
            bus.data_req = 1'b0;
        end else if (!bus.data_req && $urandom_range(0, 2) == 0) begin
            bus.data_req   = 1'b1;
            bus.data_wr    = $urandom_range(0, 1) == 1;
            bus.data_wen   = 4'($urandom_range(0, 15));
            bus.data_addr  = $urandom & 32'hFFFF_FFFC;
            bus.data_wdata = $urandom;
        end
        bus.inst_flush = ($urandom_range(0, 7) == 0);
        if (bus.inst_flush && bus.inst_req && !m_iready) bus.inst_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        @(negedge clk);
        compare_all();
        mem_agent();
        if (auto_cpu) cpu_agent();
    endtask

    task automatic wait_ready(input bit dside, input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = dside ? bus.data_ready : bus.inst_ready;
        end
        chk1(name, seen, 1'b1);
    endtask

    int nd;

    initial begin
        bus.inst_req = 0; bus.inst_addr = '0; bus.inst_flush = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_wen = '0;
        bus.data_addr = '0; bus.data_wdata = '0;
        bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
        a_lat = 0; d_lat = 0; m_cnt = 0; comb = 0; rand_mem = 0; auto_cpu = 0;
        model_reset();

        tick();
        tick();
        chk1("reset_mem_req", bus.mem_req, 1'b0);
        chk("reset_inst_rdata", bus.inst_rdata, 32'h0);
        rst = 1'b1;
        tick();

        // Lone fetch with addr_ok then data_ok on consecutive cycles.
        bus.inst_req = 1; bus.inst_addr = 32'hBFC0_0000;
        #1 chk1("lone_stall_t0", bus.inst_stall, 1'b1);
        tick();
        chk1("lone_mreq_t1", bus.mem_req, 1'b1);
        chk("lone_addr_t1", bus.mem_addr, 32'hBFC0_0000);
        tick();
        chk1("lone_mreq_t2", bus.mem_req, 1'b0);
        chk1("lone_stall_t2", bus.inst_stall, 1'b1);
        tick();
        chk1("lone_ready_t3", bus.inst_ready, 1'b1);
        chk("lone_rdata_t3", bus.inst_rdata, 32'h2408_0001);
        chk1("lone_stall_t3", bus.inst_stall, 1'b0);
        bus.inst_req = 0;
        tick();
        chk1("lone_ready_t4", bus.inst_ready, 1'b0);

        // Contention: data first, fetch granted right after.
        a_lat = 1; d_lat = 1;
        bus.inst_req = 1; bus.inst_addr = 32'hBFC0_0004;
        bus.data_req = 1; bus.data_wr = 0; bus.data_wen = 4'b0000; bus.data_addr = 32'h8000_0010;
        tick();
        chk("cont_first_data", bus.mem_addr, 32'h8000_0010);
        wait_ready(1'b1, "cont_data_ready", 20);
        bus.data_req = 0;
        tick();
        chk1("cont_gap", bus.mem_req, 1'b0);
        tick();
        chk1("cont_fetch_req", bus.mem_req, 1'b1);
        chk("cont_fetch_addr", bus.mem_addr, 32'hBFC0_0004);
        wait_ready(1'b0, "cont_inst_ready", 20);
        bus.inst_req = 0;
        tick();

        // Starvation guard: two data grants, then fetch.
        a_lat = 0; d_lat = 0; nd = 0;
        bus.inst_req = 1; bus.inst_addr = 32'hBFC0_0008;
        bus.data_req = 1; bus.data_addr = 32'h8000_0020;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.data_ready) begin nd++; bus.data_addr = bus.data_addr + 32'd4; end
            if (bus.inst_ready) break;
        end
        chk("starve_data_grants", nd, 32'd2);
        bus.inst_req = 0; bus.data_req = 0;
        tick();

        // Flush mid-fetch: first result dropped, redirected fetch returns its own word.
        a_lat = 0; d_lat = 3;
        bus.inst_req = 1; bus.inst_addr = 32'hBFC0_0100;
        tick();
        tick();
        bus.inst_flush = 1; bus.inst_addr = 32'hBFC0_0380;
        tick();
        bus.inst_flush = 0;
        wait_ready(1'b0, "flush_next_ready", 40);
        chk("flush_next_rdata", bus.inst_rdata, 32'h1A65_0380);
        bus.inst_req = 0;
        tick();

        // Store with combined handshake; load data stays as it was.
        a_lat = 0; d_lat = 0; comb = 1;
        bus.data_req = 1; bus.data_wr = 1; bus.data_wen = 4'b0011;
        bus.data_addr = 32'h8000_0040; bus.data_wdata = 32'h0000_BEEF;
        tick();
        chk1("st_mreq", bus.mem_req, 1'b1);
        chk("st_wen", {28'b0, bus.mem_wen}, 32'h3);
        chk("st_wdata", bus.mem_wdata, 32'h0000_BEEF);
        tick();
        chk1("st_ready", bus.data_ready, 1'b1);
        chk1("st_mreq_once", bus.mem_req, 1'b0);
        chk("st_rdata_kept", bus.data_rdata, 32'h25A5_0024);
        bus.data_req = 0; bus.data_wr = 0; comb = 0;
        tick();

        // Asynchronous reset during a data transfer.
        a_lat = 0; d_lat = 6;
        bus.data_req = 1; bus.data_addr = 32'h8000_0050;
        tick();
        tick();
        #2 rst = 0; bus.data_req = 0;
        #1;
        chk1("arst_mem_req", bus.mem_req, 1'b0);
        chk1("arst_data_ready", bus.data_ready, 1'b0);
        chk("arst_data_rdata", bus.data_rdata, 32'h0);
        chk("arst_inst_rdata", bus.inst_rdata, 32'h0);
        chk("arst_icnt", bus.inst_wait_cnt, 32'h0);
        chk("arst_dcnt", bus.data_wait_cnt, 32'h0);
        model_reset();
        m_cnt = 0; d_lat = 0;
        tick();
        rst = 1;
        bus.inst_req = 1; bus.inst_addr = 32'hBFC0_0000;
        wait_ready(1'b0, "arst_fetch_ready", 20);
        chk("arst_fetch_rdata", bus.inst_rdata, 32'h2408_0001);
        bus.inst_req = 0;
        tick();

        // Random traffic.
        rand_mem = 1; auto_cpu = 1;
        a_lat = $urandom_range(0, 3); d_lat = $urandom_range(0, 3);
        for (int i = 0; i < 4000; i++) tick();
        auto_cpu = 0;
        bus.inst_req = 0; bus.data_req = 0; bus.inst_flush = 0;
        for (int i = 0; i < 20; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single SRAM-like memory port between instruction fetch (F stage) and data access (M stage).
- One outstanding transaction at a time.
- Data has priority, with an anti-starvation guard for fetch.
- Drives per-side stall signals consumed by the hazard unit.
- Exception flushes cause the fetch response in flight to be discarded.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- DATA_STREAK_MAX, 2, consecutive data grants allowed while inst_req is pending before fetch is forced.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- inst_req  in  1  fetch request; held until inst_ready
- inst_addr  in  ADDR_W  fetch address (pcF)
- inst_rdata  out  DATA_W  fetched word, valid with inst_ready
- inst_ready  out  1  one-cycle completion pulse
- inst_stall  out  1  fetch waiting
- inst_flush  in  1  exception/eret flush; drop pending fetch result
- data_req  in  1  load/store request; held until data_ready
- data_wr  in  1  1 = store
- data_wen  in  4  byte enables for stores
- data_addr  in  ADDR_W  data address (aluoutM)
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data, valid with data_ready
- data_ready  out  1  one-cycle completion pulse
- data_stall  out  1  data access waiting
- mem_req  out  1  bus request
- mem_wr  out  1  bus write
- mem_wen  out  4  bus byte enables
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_addr_ok  in  1  address accepted
- mem_data_ok  in  1  data returned / write done
- mem_rdata  in  DATA_W  bus read data
- inst_wait_cnt  out  32  fetch stall cycles (optional feature)
- data_wait_cnt  out  32  data stall cycles (optional feature)

Behaviour:
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA, RESP.
- Reset: state IDLE; streak=0; discard=0. All outputs 0: mem_req, ready pulses, rdata, counters.
- IDLE grant rules:
  - If data_req and (~inst_req or streak<DATA_STREAK_MAX): latch data_wr, data_wen, data_addr, data_wdata. Go to D_ADDR. streak++ if inst_req, else streak=0.
  - Else if inst_req: latch inst_addr, go to I_ADDR, streak=0.
- *_ADDR states:
  - mem_req=1; mem_* driven from latched fields, stable until mem_addr_ok.
  - Instruction transactions drive mem_wr=0 and mem_wen=0.
  - On addr_ok: go to *_DATA.
  - addr_ok and data_ok in the same cycle: go directly to RESP.
- *_DATA states:
  - mem_req=0.
  - On data_ok: register mem_rdata into the side's rdata, go to RESP.
- RESP:
  - Pulse the owning side's ready for one cycle, return to IDLE.
  - The held req is not re-sampled in RESP.
- Latency: req seen in IDLE cycle t; mem_req at t+1. Zero-wait memory gives ready at t+2 (combined ok) or t+3.
- Stall outputs:
  - inst_stall = inst_req & ~inst_ready.
  - data_stall = data_req & ~data_ready.
  - Both combinational.
- Flush:
  - inst_flush while a fetch is in I_ADDR/I_DATA sets discard.
  - The bus transaction still completes; mem_req is never withdrawn once asserted.
  - In RESP with discard set, inst_ready stays 0; discard clears.
  - inst_flush in IDLE has no effect.
  - Data transactions are never flushed.
- Writes: data_rdata is undefined-but-stable (unchanged) on store completion; data_ready still pulses.
- Reset mid-operation: abandons the in-flight bus transaction. The memory side must be reset by the same rst.
- rdata registers hold their value until the next completion on that side.

Optional Feature:
- Macro: MEM_BUS_ARBITER_PERF_CNT_EN.
- With the macro:
  - inst_wait_cnt increments each cycle inst_stall=1.
  - data_wait_cnt increments each cycle data_stall=1.
  - Both wrap at 2^32 and reset to 0.
- Without the macro: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding (6 states, 3-bit enum);
  - ADDR_W/DATA_W defaults;
  - byte-enable constant WEN_NONE=4'b0000.
- Sub-module mem_bus_perf_cnt (two saturating-free wrap counters), instantiated only under the macro.
- Arbiter FSM, request latches and stall logic stay in the top module.

Test Plan:
- Lone fetch: inst_req=1, inst_addr=0xBFC00000; memory gives addr_ok at t+1, data_ok at t+2 with 0x24080001 -> inst_ready pulse at t+3, inst_rdata=0x24080001, inst_stall high t..t+2.
- Contention: inst_req and data_req (load 0x80000010) raised together -> data granted first; fetch granted immediately after data_ready; no overlapping mem_req.
- Starvation guard: data_req held continuously with new loads while inst_req is pending -> after 2 data grants, fetch is granted on the third arbitration.
- Flush mid-fetch: inst_flush pulsed in I_DATA -> mem transaction completes, inst_ready stays 0, next fetch (0xBFC00380) returns its own data correctly.
- Store with combined handshake: data_wr=1, data_wen=4'b0011, wdata=0x0000BEEF; addr_ok and data_ok in the same cycle -> mem_wen=4'b0011 seen once, data_ready pulse next cycle, data_rdata unchanged.
- Async reset asserted during D_DATA -> all outputs 0 immediately, state IDLE; a fresh fetch after release completes normally; counters read 0 (macro on).
